// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: multi-cycle load/store with
// programmable wait states, byte/half/word sizing, sign/zero extension
// and alignment/legality checking. Holds the pipeline via stall.
module dmem_responder #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        stall,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;
    logic            commit;
    logic            req;
    logic            is_load, is_store;
    logic            load_legal, store_legal, misalign, acc_err;
    logic [AW-1:0]   idx;
    logic [31:0]     word_rd, shifted, load_data;
    logic [31:0]     wr_data, merged;
    logic [3:0]      byte_en;
    logic [31:0]     mem [DEPTH];

    assign req        = mem_read | mem_write;
    assign idx        = addr[2 +: AW];
    assign resp_valid = (state == RESP);
    assign stall      = req & ~resp_valid;

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; commit marks the edge that enters RESP
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request decode, legality and alignment checking
    always_comb begin
        is_load  = mem_read & ~mem_write;
        is_store = mem_write & ~mem_read;
        case (func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_legal = 1'b1;
            default:                                 load_legal = 1'b0;
        endcase
        case (func3)
            3'b000, 3'b001, 3'b010: store_legal = 1'b1;
            default:                store_legal = 1'b0;
        endcase
        misalign = ((func3[1:0] == 2'b01) & addr[0]) |
                   ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        acc_err  = (mem_read & mem_write) |
                   (is_load & ~load_legal) |
                   (is_store & ~store_legal) |
                   misalign;
    end

    // Load lane selection and extension
    always_comb begin
        word_rd = mem[idx];
        shifted = word_rd >> {addr[1:0], 3'b000};
        case (func3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = word_rd;
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    // Store lane enables and read-modify-write merge
    always_comb begin
        case (func3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr[1:0];
                wr_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = wdata;
            end
        endcase
        merged = word_rd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Memory array: written only at a clean store commit, never reset
    always_ff @(posedge clk) begin
        if (!reset && commit && is_store && !acc_err) begin
            mem[idx] <= merged;
        end
    end

    // Response registers captured at the commit edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (commit) begin
            err   <= acc_err;
            rdata <= (is_load && !acc_err) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Instance 0 runs with
// two wait states, instance 1 with none; both share clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mrd [2];
    logic        mwr [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [2:0]  f3  [2];
    logic [31:0] rd  [2];
    logic        rv  [2];
    logic        st  [2];
    logic        er  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(reset), .mem_read(mrd[0]), .mem_write(mwr[0]),
        .addr(ad[0]), .wdata(wd[0]), .func3(f3[0]), .rdata(rd[0]),
        .resp_valid(rv[0]), .stall(st[0]), .err(er[0])
    );

    dmem_responder #(.DEPTH(128), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .mem_read(mrd[1]), .mem_write(mwr[1]),
        .addr(ad[1]), .wdata(wd[1]), .func3(f3[1]), .rdata(rd[1]),
        .resp_valid(rv[1]), .stall(st[1]), .err(er[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full handshake; checks latency and stall window, returns response
    task automatic acc(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input string tag, output logic [31:0] data, output logic e);
        int lat;
        int cyc;
        int stalls;
        bit got;
        lat    = (s == 0) ? 3 : 1;
        cyc    = 0;
        stalls = 0;
        got    = 1'b0;
        @(posedge clk);
        #1;
        mrd[s] = r; mwr[s] = w; ad[s] = a; wd[s] = d; f3[s] = f;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv[s]) begin
                cyc = i;
                got = 1'b1;
                break;
            end
            if (st[s]) stalls++;
        end
        check({tag, "/done"}, 32'(got), 32'd1);
        check({tag, "/lat"}, cyc, lat);
        check({tag, "/stall_cycles"}, stalls, lat);
        check({tag, "/stall_in_resp"}, 32'(st[s]), 32'd0);
        data = rd[s];
        e    = er[s];
        mrd[s] = 1'b0;
        mwr[s] = 1'b0;
    endtask

    task automatic ld(input int s, input logic [31:0] a, input logic [2:0] f, input string tag,
                      input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        acc(s, 1'b1, 1'b0, a, 32'h0, f, tag, d, e);
        check({tag, "/rdata"}, d, exp_d);
        check({tag, "/err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic sto(input int s, input logic [31:0] a, input logic [31:0] v, input logic [2:0] f,
                       input string tag, input logic exp_e);
        logic [31:0] d;
        logic        e;
        acc(s, 1'b0, 1'b1, a, v, f, tag, d, e);
        check({tag, "/err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mrd[s] = 1'b0; mwr[s] = 1'b0; ad[s] = '0; wd[s] = '0; f3[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset/rdata", rd[s], 32'h0);
            check("reset/err", 32'(er[s]), 32'd0);
            check("reset/resp_valid", 32'(rv[s]), 32'd0);
            check("reset/stall", 32'(st[s]), 32'd0);
        end

        // Word store/load round trip
        sto(0, 32'h10, 32'hDEADBEEF, 3'b010, "sw_10", 1'b0);
        ld (0, 32'h10, 3'b010, "lw_10", 32'hDEADBEEF, 1'b0);

        // Byte store into lane 3, then signed/unsigned/word readback
        sto(0, 32'h13, 32'h00000081, 3'b000, "sb_13", 1'b0);
        ld (0, 32'h13, 3'b000, "lb_13",  32'hFFFFFF81, 1'b0);
        ld (0, 32'h13, 3'b100, "lbu_13", 32'h00000081, 1'b0);
        ld (0, 32'h10, 3'b010, "lw_10b", 32'h81ADBEEF, 1'b0);
        ld (0, 32'h12, 3'b001, "lh_12",  32'hFFFF81AD, 1'b0);
        ld (0, 32'h10, 3'b101, "lhu_10", 32'h0000BEEF, 1'b0);

        // Error cases: misaligned, illegal func3, read+write together
        ld (0, 32'h11, 3'b001, "lh_11_misal", 32'h0, 1'b1);
        sto(0, 32'h12, 32'h11223344, 3'b010, "sw_12_misal", 1'b1);
        ld (0, 32'h10, 3'b011, "ld_f3_011", 32'h0, 1'b1);
        sto(0, 32'h10, 32'h55555555, 3'b100, "st_f3_100", 1'b1);
        acc(0, 1'b1, 1'b1, 32'h10, 32'h66666666, 3'b010, "rw_both", d, e);
        check("rw_both/err", 32'(e), 32'd1);
        check("rw_both/rdata", d, 32'h0);
        ld (0, 32'h10, 3'b010, "lw_10_after_err", 32'h81ADBEEF, 1'b0);

        // Upper half store leaves lower half unchanged
        sto(0, 32'h12, 32'hCAFE1234, 3'b001, "sh_12", 1'b0);
        ld (0, 32'h10, 3'b010, "lw_10_sh", 32'h1234BEEF, 1'b0);

        // Address wrap modulo DEPTH*4
        sto(0, 32'h200, 32'h12345678, 3'b010, "sw_200", 1'b0);
        ld (0, 32'h0, 3'b010, "lw_0_wrap", 32'h12345678, 1'b0);

        // Zero wait states: back-to-back loads
        sto(1, 32'h0, 32'h11111111, 3'b010, "w0_sw_0", 1'b0);
        sto(1, 32'h4, 32'h22222222, 3'b010, "w0_sw_4", 1'b0);
        ld (1, 32'h0, 3'b010, "w0_lw_0", 32'h11111111, 1'b0);
        ld (1, 32'h4, 3'b010, "w0_lw_4", 32'h22222222, 1'b0);

        // Reset during WAIT abandons the store
        sto(0, 32'h20, 32'h0BADF00D, 3'b010, "sw_20_prior", 1'b0);
        ld (0, 32'h20, 3'b010, "lw_20_prior", 32'h0BADF00D, 1'b0);
        @(posedge clk);
        #1;
        mwr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'hAAAA5555; f3[0] = 3'b010;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mwr[0] = 1'b0;
        @(negedge clk);
        check("midrst/rdata", rd[0], 32'h0);
        check("midrst/err", 32'(er[0]), 32'd0);
        check("midrst/resp_valid", 32'(rv[0]), 32'd0);
        check("midrst/stall", 32'(st[0]), 32'd0);
        ld (0, 32'h20, 3'b010, "lw_20_after_rst", 32'h0BADF00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
